// File: rtl/mips_instr_fetch_if.sv
// Fetch-stage bus bundle: byte-wide instruction memory port, execute redirect,
// and the valid/ready word handshake toward decode.
interface mips_instr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              align_fault;

  modport master (
    output mem_rd_en, mem_addr, instr_valid, instr, instr_pc, align_fault,
    input  mem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, instr_valid, instr, instr_pc, align_fault,
    output mem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/mips_instr_fetch.sv
// MIPS fetch stage: four byte reads per little-endian word, handed to decode by valid/ready.
// Optional MIPS_FETCH_ALIGN_CHECK_EN: misaligned redirect raises align_fault and idles the fetcher.
module mips_instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                reset,
  mips_instr_fetch_if.master bus
);
  localparam int STAGES = 1;

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD, IDLE} state_t;

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        pc, pc_nxt, base, addr_q;
  logic [1:0]               byte_idx, byte_idx_nxt, issue_idx;
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0][1:0]     idx_pipe;
  logic [31:0]              instr_q;
  logic                     instr_valid_q, valid_nxt;
  logic                     fault_q, fault_nxt;
  logic                     issue, capture, last_byte, handshake, misalign;

  // vld_pipe[0] is the read strobe this cycle; vld_pipe[1] marks mem_rdata as live.
  assign handshake = instr_valid_q && bus.instr_ready;
  assign misalign  = ALIGN_CHK && (bus.redirect_pc[1:0] != 2'b00);
  assign capture   = vld_pipe[STAGES] && !bus.redirect_valid;
  assign last_byte = capture && (idx_pipe[STAGES] == 2'd3);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    byte_idx_nxt = byte_idx;
    valid_nxt    = instr_valid_q;
    fault_nxt    = fault_q;
    issue        = 1'b0;
    issue_idx    = byte_idx;
    base         = pc;
    if (bus.redirect_valid) begin
      pc_nxt    = bus.redirect_pc;
      base      = bus.redirect_pc;
      valid_nxt = 1'b0;
      fault_nxt = misalign;
      issue_idx = 2'd0;
      if (misalign) begin
        byte_idx_nxt = 2'd0;
        state_nxt    = IDLE;
      end else begin
        issue        = 1'b1;
        byte_idx_nxt = 2'd1;
        state_nxt    = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          issue        = 1'b1;
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_nxt = DRAIN;
        end
        DRAIN: begin
          if (last_byte) begin
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          // Start the next word on the handshake edge so words arrive every 6 cycles.
          if (handshake) begin
            pc_nxt       = pc + ADDR_W'(4);
            base         = pc + ADDR_W'(4);
            valid_nxt    = 1'b0;
            issue        = 1'b1;
            issue_idx    = 2'd0;
            byte_idx_nxt = 2'd1;
            state_nxt    = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      byte_idx      <= 2'd0;
      vld_pipe      <= '0;
      idx_pipe      <= '0;
      addr_q        <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      byte_idx      <= byte_idx_nxt;
      instr_valid_q <= valid_nxt;
      fault_q       <= fault_nxt;
      // A redirect kills the byte already in flight from the old stream.
      vld_pipe      <= {vld_pipe[0] & ~bus.redirect_valid, issue};
      idx_pipe      <= {idx_pipe[0], issue_idx};
      if (issue)   addr_q <= base + ADDR_W'(issue_idx);
      if (capture) instr_q[8*idx_pipe[STAGES] +: 8] <= bus.mem_rdata;
    end
  end

  assign bus.mem_rd_en   = vld_pipe[0];
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = pc;
  assign bus.align_fault = ALIGN_CHK ? fault_q : 1'b0;
endmodule
